rhythm_scoreboard: RTL and testbench

Parametrised scoring engine for NUM_PLAYERS independent players, each with LANES arrow inputs. Every input is judged once per pattern against a timing window, producing perfect, good, miss or wrong-press outcomes. The block tracks a consecutive-hit combo with a capped score multiplier and saturates scores at SCORE_MAX. It sits between the input-processing/pattern-generator stage and the display/controller, which read its registered score, result and combo outputs.

---
 rtl/rhythm_scoreboard.sv | 180 ++++++++++++++++++
 tb/tb_rhythm_scoreboard.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rhythm_scoreboard.sv
// Multi-player rhythm-game judge: times each chord press against a window and
// keeps per-player score, combo, multiplier and last result, all registered.
module rhythm_scoreboard #(
  parameter int NUM_PLAYERS    = 2,
  parameter int LANES          = 4,
  parameter int TIMER_W        = 20,
  parameter int SCORE_W        = 14,
  parameter int SCORE_MAX      = 9999,
  parameter int PERFECT_WINDOW = 125000,
  parameter int GOOD_WINDOW    = 250000,
  parameter int TOTAL_WINDOW   = 500000,
  parameter int PERFECT_POINTS = 10,
  parameter int GOOD_POINTS    = 5,
  parameter int PENALTY_POINTS = 5,
  parameter int COMBO_W        = 8,
  parameter int COMBO_STEP     = 10,
  parameter int MAX_MULT       = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             game_active,
  input  logic                             pattern_new,
  input  logic                             pattern_valid,
  input  logic [TIMER_W-1:0]               pattern_timer,
  input  logic [NUM_PLAYERS*LANES-1:0]     player_in,
  input  logic [NUM_PLAYERS*LANES-1:0]     pattern,
  output logic [NUM_PLAYERS*SCORE_W-1:0]   score,
  output logic [NUM_PLAYERS*2-1:0]         last_hit,
  output logic [NUM_PLAYERS*COMBO_W-1:0]   combo,
  output logic [NUM_PLAYERS-1:0]           hit_pulse
);

  localparam int ARITH_W = SCORE_W + 3;
  localparam int MULT_W  = $clog2(MAX_MULT + 1);
  localparam int STEP_W  = $clog2(COMBO_STEP + 1);

  localparam logic [TIMER_W-1:0] PERFECT_T = TIMER_W'(PERFECT_WINDOW);
  localparam logic [TIMER_W-1:0] GOOD_T    = TIMER_W'(GOOD_WINDOW);
  localparam logic [TIMER_W-1:0] TOTAL_T   = TIMER_W'(TOTAL_WINDOW);

  localparam logic [ARITH_W-1:0] SCORE_MAX_A = ARITH_W'(SCORE_MAX);
  localparam logic [ARITH_W-1:0] PERFECT_A   = ARITH_W'(PERFECT_POINTS);
  localparam logic [ARITH_W-1:0] GOOD_A      = ARITH_W'(GOOD_POINTS);
  localparam logic [ARITH_W-1:0] PENALTY_A   = ARITH_W'(PENALTY_POINTS);

  localparam logic [MULT_W-1:0]  MULT_ONE  = MULT_W'(1);
  localparam logic [MULT_W-1:0]  MULT_CAP  = MULT_W'(MAX_MULT);
  localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(COMBO_STEP - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
    state_t               state_q, state_d;
    logic [LANES-1:0]     prev_q, prev_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [COMBO_W-1:0]   combo_q, combo_d;
    logic [1:0]           last_q, last_d;
    logic                 pulse_q, pulse_d;
    logic [MULT_W-1:0]    mult_q, mult_d;
    logic [STEP_W-1:0]    step_q, step_d;

    logic [LANES-1:0]     in_w, pat_w;
    logic                 press, judge;
    logic                 hit, miss, wrong;
    logic [ARITH_W-1:0]   base, award, sum, cur;

    assign in_w = player_in[gi*LANES +: LANES];
    assign pat_w = pattern[gi*LANES +: LANES];

    always_comb begin
      state_d = state_q;
      prev_d  = in_w;
      score_d = score_q;
      combo_d = combo_q;
      last_d  = last_q;
      pulse_d = 1'b0;
      mult_d  = mult_q;
      step_d  = step_q;
      hit     = 1'b0;
      miss    = 1'b0;
      wrong   = 1'b0;
      base    = '0;
      press   = (in_w != prev_q) && (in_w != '0);
      judge   = press && pattern_valid;

      // A fresh pattern swallows any coincident press; judging starts next cycle.
      if (!game_active) begin
        state_d = ST_IDLE;
      end else if (pattern_new) begin
        state_d = ST_ARMED;
      end else if (state_q == ST_ARMED) begin
        if (judge && (pattern_timer <= TOTAL_T)) begin
          if (in_w == pat_w) begin
            state_d = ST_DONE;
            if (pattern_timer <= PERFECT_T) begin
              hit    = 1'b1;
              base   = PERFECT_A;
              last_d = 2'b10;
            end else if (pattern_timer <= GOOD_T) begin
              hit    = 1'b1;
              base   = GOOD_A;
              last_d = 2'b01;
            end else begin
              miss = 1'b1;
            end
          end else begin
            wrong = 1'b1;
          end
        end else if (!judge && (pattern_timer > TOTAL_T)) begin
          miss    = 1'b1;
          state_d = ST_DONE;
        end
      end

      cur   = ARITH_W'(score_q);
      award = base * ARITH_W'(mult_q);
      sum   = cur + award;

      if (hit) begin
        pulse_d = 1'b1;
        score_d = (sum > SCORE_MAX_A) ? SCORE_W'(SCORE_MAX_A) : SCORE_W'(sum);
        if (combo_q != '1) begin
          combo_d = combo_q + 1'b1;
        end
        // Multiplier steps on every COMBO_STEP-th consecutive hit, independent of combo saturation.
        if (step_q == STEP_LAST) begin
          step_d = '0;
          if (mult_q != MULT_CAP) begin
            mult_d = mult_q + 1'b1;
          end
        end else begin
          step_d = step_q + 1'b1;
        end
      end else if (miss || wrong) begin
        pulse_d = 1'b1;
        combo_d = '0;
        mult_d  = MULT_ONE;
        step_d  = '0;
        if (wrong) begin
          last_d  = 2'b11;
          score_d = (cur < PENALTY_A) ? '0 : SCORE_W'(cur - PENALTY_A);
        end else begin
          last_d = 2'b00;
        end
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        state_q <= ST_IDLE;
        prev_q  <= '0;
        score_q <= '0;
        combo_q <= '0;
        last_q  <= 2'b00;
        pulse_q <= 1'b0;
        mult_q  <= MULT_ONE;
        step_q  <= '0;
      end else begin
        state_q <= state_d;
        prev_q  <= prev_d;
        score_q <= score_d;
        combo_q <= combo_d;
        last_q  <= last_d;
        pulse_q <= pulse_d;
        mult_q  <= mult_d;
        step_q  <= step_d;
      end
    end

    assign score[gi*SCORE_W +: SCORE_W]   = score_q;
    assign last_hit[gi*2 +: 2]            = last_q;
    assign combo[gi*COMBO_W +: COMBO_W]   = combo_q;
    assign hit_pulse[gi]                  = pulse_q;
  end

endmodule

// File: tb/tb_rhythm_scoreboard.sv
// Directed and randomized checks of rhythm_scoreboard against a rule-level model.
module tb_rhythm_scoreboard;
  localparam int NP = 2;
  localparam int L  = 4;
  localparam int SW = 14;
  localparam int CW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          game_active;
  logic          pattern_new;
  logic          pattern_valid;
  logic [19:0]   pattern_timer;
  logic [NP*L-1:0] player_in;
  logic [NP*L-1:0] pattern;
  logic [NP*SW-1:0] score;
  logic [NP*2-1:0]  last_hit;
  logic [NP*CW-1:0] combo;
  logic [NP-1:0]    hit_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per-player judged/armed status and consecutive-hit run length.
  int       m_score[NP];
  int       m_combo[NP];
  int       m_run[NP];
  int       m_last[NP];
  int       m_pulse[NP];
  bit       m_armed[NP];
  logic [L-1:0] m_prev[NP];

  logic [L-1:0] pat0, pat1;

  rhythm_scoreboard dut (
    .clock         (clock),
    .reset         (reset),
    .game_active   (game_active),
    .pattern_new   (pattern_new),
    .pattern_valid (pattern_valid),
    .pattern_timer (pattern_timer),
    .player_in     (player_in),
    .pattern       (pattern),
    .score         (score),
    .last_hit      (last_hit),
    .combo         (combo),
    .hit_pulse     (hit_pulse)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_miss(input int p, input int code);
    m_pulse[p] = 1;
    m_last[p]  = code;
    m_combo[p] = 0;
    m_run[p]   = 0;
  endfunction

  function automatic void model_edge();
    for (int p = 0; p < NP; p++) begin
      logic [L-1:0] in_v, pat_v;
      bit press;
      int t, mult, base;
      in_v  = player_in[p*L +: L];
      pat_v = pattern[p*L +: L];
      press = (in_v != m_prev[p]) && (in_v != 0) && pattern_valid;
      t     = int'(pattern_timer);
      m_pulse[p] = 0;
      if (reset) begin
        m_score[p] = 0; m_combo[p] = 0; m_run[p] = 0; m_last[p] = 0;
        m_armed[p] = 0; m_prev[p] = '0;
        continue;
      end
      if (!game_active) m_armed[p] = 0;
      else if (pattern_new) m_armed[p] = 1;
      else if (m_armed[p]) begin
        if (press && t <= 500000) begin
          if (in_v == pat_v) begin
            m_armed[p] = 0;
            if (t <= 250000) begin
              base = (t <= 125000) ? 10 : 5;
              mult = 1 + m_run[p] / 10;
              if (mult > 4) mult = 4;
              m_score[p] = m_score[p] + base * mult;
              if (m_score[p] > 9999) m_score[p] = 9999;
              if (m_combo[p] < 255) m_combo[p]++;
              m_run[p]++;
              m_last[p]  = (t <= 125000) ? 2 : 1;
              m_pulse[p] = 1;
            end else begin
              model_miss(p, 0);
            end
          end else begin
            model_miss(p, 3);
            m_score[p] = (m_score[p] < 5) ? 0 : m_score[p] - 5;
          end
        end else if (!press && t > 500000) begin
          m_armed[p] = 0;
          model_miss(p, 0);
        end
      end
      m_prev[p] = in_v;
    end
  endfunction

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    for (int p = 0; p < NP; p++) begin
      check($sformatf("score%0d", p), 32'(score[p*SW +: SW]), m_score[p]);
      check($sformatf("last_hit%0d", p), 32'(last_hit[p*2 +: 2]), m_last[p]);
      check($sformatf("combo%0d", p), 32'(combo[p*CW +: CW]), m_combo[p]);
      check($sformatf("hit_pulse%0d", p), 32'(hit_pulse[p]), m_pulse[p]);
    end
  endtask

  task automatic drive(input logic rst, input logic ga, input logic pn, input logic pv,
                       input int tmr, input logic [L-1:0] i0, input logic [L-1:0] i1);
    reset         = rst;
    game_active   = ga;
    pattern_new   = pn;
    pattern_valid = pv;
    pattern_timer = 20'(tmr);
    player_in     = {i1, i0};
    pattern       = {pat1, pat0};
    step();
  endtask

  int s0, s1;
  int tt[8];
  logic [L-1:0] rin[NP];

  initial begin
    pat0 = 4'b0001; pat1 = 4'b0100;
    drive(1, 0, 0, 0, 0, 0, 0);
    check("reset_score0", 32'(score[0 +: SW]), 0);
    check("reset_pulse", 32'(hit_pulse), 0);

    // Perfect then good on player 0
    drive(0, 1, 1, 1, 0, 0, 0);
    drive(0, 1, 0, 1, 100, 4'b0001, 0);
    check("perfect_score0", 32'(score[0 +: SW]), 10);
    check("perfect_last0", 32'(last_hit[1:0]), 2);
    check("perfect_combo0", 32'(combo[0 +: CW]), 1);
    drive(0, 1, 0, 1, 150, 4'b0001, 0);
    check("pulse_one_cycle", 32'(hit_pulse[0]), 0);
    drive(0, 1, 1, 1, 0, 0, 0);
    drive(0, 1, 0, 1, 200000, 4'b0001, 0);
    check("good_score0", 32'(score[0 +: SW]), 15);
    check("good_last0", 32'(last_hit[1:0]), 1);

    // Wrong press on player 1 floors at zero, then a match still counts
    drive(0, 1, 0, 1, 1000, 4'b0001, 4'b0010);
    check("wrong_last1", 32'(last_hit[3:2]), 3);
    check("wrong_score1", 32'(score[SW +: SW]), 0);
    drive(0, 1, 0, 1, 2000, 4'b0001, 4'b0100);
    check("after_wrong_score1", 32'(score[SW +: SW]), 10);

    // Timeout, late hit, press while done
    drive(0, 1, 1, 1, 0, 0, 0);
    drive(0, 1, 0, 1, 500001, 0, 0);
    check("timeout_last0", 32'(last_hit[1:0]), 0);
    check("timeout_pulse", 32'(hit_pulse), 2'b11);
    drive(0, 1, 0, 1, 500002, 0, 0);
    check("timeout_once", 32'(hit_pulse), 0);
    drive(0, 1, 1, 1, 0, 0, 0);
    drive(0, 1, 0, 1, 400000, 4'b0001, 0);
    check("late_score0", 32'(score[0 +: SW]), 15);
    drive(0, 1, 0, 1, 400010, 4'b0011, 0);
    check("done_ignored", 32'(hit_pulse), 0);

    // Multiplier: 10 perfects add 100, the 11th adds 20
    s0 = int'(score[0 +: SW]);
    for (int k = 0; k < 11; k++) begin
      drive(0, 1, 1, 1, 0, 0, 0);
      drive(0, 1, 0, 1, 100, 4'b0001, 0);
      if (k == 9) check("mult_ten", 32'(score[0 +: SW]), 32'(s0 + 100));
    end
    check("mult_eleventh", 32'(score[0 +: SW]), 32'(s0 + 120));
    drive(0, 1, 1, 1, 0, 0, 0);
    drive(0, 1, 0, 1, 100, 4'b1000, 0);
    drive(0, 1, 0, 1, 200, 4'b0001, 0);
    check("mult_reset", 32'(score[0 +: SW]), 32'(s0 + 125));

    // Press coincident with pattern_new is ignored; player stays armed
    drive(0, 1, 1, 1, 100, 4'b0010, 0);
    check("collision_pulse", 32'(hit_pulse), 0);
    drive(0, 1, 0, 1, 100, 4'b0001, 0);
    check("collision_armed", 32'(last_hit[1:0]), 2);

    // Reset mid-pattern
    drive(0, 1, 1, 1, 0, 0, 0);
    drive(1, 1, 0, 1, 100, 4'b0001, 4'b0100);
    check("midreset_score", 32'(score), 0);
    check("midreset_combo", 32'(combo), 0);

    // Saturation with both players scoring in the same cycles
    for (int k = 0; k < 270; k++) begin
      drive(0, 1, 1, 1, 0, 0, 0);
      drive(0, 1, 0, 1, 100, pat0, pat1);
    end
    check("sat_score0", 32'(score[0 +: SW]), 9999);
    check("sat_score1", 32'(score[SW +: SW]), 9999);
    check("sat_combo0", 32'(combo[0 +: CW]), 255);

    // Randomized play
    for (int k = 0; k < 3000; k++) begin
      tt[0] = 100; tt[1] = 125000; tt[2] = 125001; tt[3] = 250000;
      tt[4] = 250001; tt[5] = 500000; tt[6] = 500001;
      tt[7] = int'($urandom_range(0, 600000));
      for (int p = 0; p < NP; p++) begin
        case ($urandom_range(0, 3))
          0: rin[p] = player_in[p*L +: L];
          1: rin[p] = '0;
          2: rin[p] = (p == 0) ? pat0 : pat1;
          default: rin[p] = L'($urandom);
        endcase
      end
      if (pattern_new) begin
        pat0 = L'($urandom_range(1, 15));
        pat1 = L'($urandom_range(1, 15));
      end
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) != 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) != 0),
            tt[$urandom_range(0, 7)], rin[0], rin[1]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
